// File: rtl/mode_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot terminal behaviour.
// Registered dout, single-cycle tc pulse, sticky done flag cleared by clr or load.
module mode_counter #(
  parameter int N  = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  input  logic [N-1:0]  limit,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] presc,
  output logic [N-1:0]  dout,
  output logic          tc,
  output logic          done
);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [PW-1:0] p;
  logic [PW-1:0] p_nxt;
  logic [N-1:0]  dout_nxt;
  logic          tc_nxt;
  logic          done_nxt;
  logic          step;
  logic          at_term;

  // p >= presc (not ==) so a lowered presc never strands p above the compare.
  assign step    = en && (p >= presc);
  assign at_term = dir ? (dout >= limit) : (dout == '0);

  always_comb begin
    p_nxt    = p;
    dout_nxt = dout;
    tc_nxt   = 1'b0;
    done_nxt = done;
    if (clr) begin
      p_nxt    = '0;
      dout_nxt = '0;
      done_nxt = 1'b0;
    end else if (load) begin
      p_nxt    = '0;
      dout_nxt = load_val;
      done_nxt = 1'b0;
    end else if (en) begin
      p_nxt = step ? '0 : p + PW'(1);
      // Once a one-shot has completed, steps are swallowed until clr/load.
      if (step && !done) begin
        if (!at_term) begin
          dout_nxt = dir ? dout + N'(1) : dout - N'(1);
        end else begin
          tc_nxt = 1'b1;
          case (mode)
            MODE_SAT:     dout_nxt = dout;
            MODE_ONESHOT: done_nxt = 1'b1;
            default:      dout_nxt = dir ? '0 : limit;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p    <= '0;
      dout <= '0;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      p    <= p_nxt;
      dout <= dout_nxt;
      tc   <= tc_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter N, default 16, counter width in bits (N >= 2).
REQ-002 Parameter PW, default 8, prescaler width in bits (PW >= 1).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable; gates the prescaler and the counter.
REQ-006 clr  input  1  synchronous clear.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  N  value written to the counter on load.
REQ-009 limit  input  N  terminal value for up-counting; reload value for down-wrap.
REQ-010 dir  input  1  count direction: 1 = up, 0 = down.
REQ-011 mode  input  2  count mode: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = wrap.
REQ-012 presc  input  PW  prescale ratio; one count step SHALL occur every presc+1 enabled cycles.
REQ-013 dout  output  N  current count, registered.
REQ-014 tc  output  1  terminal-count pulse, registered.
REQ-015 done  output  1  one-shot complete flag, sticky.

Function
REQ-016 Command priority per cycle SHALL be: clr, then load, then count step.
REQ-017 clr SHALL set dout=0, prescaler=0, done=0 and tc=0 on the next edge.
REQ-018 load SHALL set dout=load_val, prescaler=0, done=0 and tc=0 on the next edge.
REQ-019 With en=0 the prescaler and dout SHALL hold; tc SHALL be 0.
REQ-020 Prescaler p: with en=1 and no clr/load, p SHALL increment; when p>=presc, p SHALL return to 0 and a step event SHALL occur in that cycle.
REQ-021 presc=0 SHALL produce a step event on every enabled cycle.
REQ-022 Terminal condition: up when dout>=limit; down when dout==0.
REQ-023 On a step event, if not terminal, dout SHALL change by +1 (up) or -1 (down), with no modular overflow past limit or 0.
REQ-024 On a step event at terminal in wrap mode, dout SHALL become 0 (up) or limit (down).
REQ-025 On a step event at terminal in saturate mode, dout SHALL hold.
REQ-026 On a step event at terminal in one-shot mode, dout SHALL hold and done SHALL be set to 1.
REQ-027 While done=1, step events SHALL be suppressed (dout holds, tc=0) until clr or load.
REQ-028 tc SHALL be 1 for exactly the one cycle after each unsuppressed step event taken at terminal, in any mode.
REQ-029 Changing dir, mode, limit or presc mid-count SHALL take effect on the next cycle, with no glitch and no reset of p.
REQ-030 If limit=0: up-wrap SHALL hold dout at 0 with tc on every step, and down-wrap SHALL reload 0.
REQ-031 Up-count with dout>limit (limit lowered) SHALL be treated as terminal per REQ-022 through REQ-026.
REQ-032 Counter arithmetic SHALL be unsigned N-bit; p SHALL be unsigned PW-bit.

Reset
REQ-033 rst_n=0 SHALL immediately force dout=0, p=0, tc=0 and done=0, independent of clk.
REQ-034 Reset deassertion SHALL occur synchronously to clk; the first step SHALL occur no earlier than presc+1 enabled cycles after release.
REQ-035 Reset asserted mid-count or mid-pulse SHALL abort the operation with no residual tc.

Verification
REQ-036 Wrap up: limit=3, presc=0, dir=1, mode=00, en=1 from reset -> dout 0,1,2,3,0,1..., with tc high the cycle dout returns to 0.
REQ-037 Prescale and down: presc=2, dir=0, limit=5, load_val=2 loaded -> dout steps every 3rd cycle 2,1,0,5, with tc once at the 0->5 reload.
REQ-038 One-shot: mode=10, limit=4, dir=1 -> dout reaches 4; next step sets done=1 with one tc; dout stays 4 for 20 cycles; then load of 1 -> done=0 and counting resumes.
REQ-039 Saturate down: mode=01, dir=0, start at 1 -> dout 1,0,0,0 with tc on each step at 0; done stays 0.
REQ-040 Priority: clr=1 and load=1 with load_val=7 in the same cycle -> dout=0; then load alone -> dout=7.
REQ-041 Async reset: assert rst_n=0 between edges while dout=9 -> dout=0 and tc=0 before the next edge; after release, the first step occurs presc+1 cycles later.
